// File: rtl/cla_result_stage.sv
// Result stage behind the 16-bit CLA adder: captures sum/carry, derives C/Z/N/V flags and
// presents them on a valid/ready port through a 2-entry skid buffer, counting deliveries.
module cla_result_stage #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   S,
    input  logic               C16,
    input  logic               A_msb,
    input  logic               B_msb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_c,
    output logic               out_z,
    output logic               out_n,
    output logic               out_v,
    output logic [COUNT_W-1:0] result_count
);

    // Entry layout: {sum, c, z, n, v}; an entry always moves as one word.
    localparam int unsigned EW = WIDTH + 4;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]         r_state;
    logic [EW-1:0]      r_main;
    logic [EW-1:0]      r_skid;
    logic [COUNT_W-1:0] r_count;

    logic [1:0]         w_state_nxt;
    logic [EW-1:0]      w_main_nxt;
    logic [EW-1:0]      w_skid_nxt;
    logic [COUNT_W-1:0] w_count_nxt;

    logic               w_in_z;
    logic               w_in_n;
    logic               w_in_v;
    logic [EW-1:0]      w_in_entry;
    logic               w_accept;
    logic               w_xfer;

    // Flags are derived on the input side so the stored entry is self-contained.
    assign w_in_z     = (S == '0);
    assign w_in_n     = S[WIDTH-1];
    assign w_in_v     = (A_msb == B_msb) && (S[WIDTH-1] != A_msb);
    assign w_in_entry = {S, C16, w_in_z, w_in_n, w_in_v};

    assign in_ready  = !Rst && (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = w_in_entry;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_xfer) begin
                    w_state_nxt = ST_FULL;
                    w_skid_nxt  = w_in_entry;
                end else if (w_xfer && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_xfer && w_accept) begin
                    w_main_nxt  = w_in_entry;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_xfer) begin
            w_count_nxt = r_count + COUNT_W'(1);
        end
    end

    // Reset wins over any accept/transfer in the same cycle and discards buffered data.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign out_sum      = r_main[EW-1:4];
    assign out_c        = r_main[3];
    assign out_z        = r_main[2];
    assign out_n        = r_main[1];
    assign out_v        = r_main[0];
    assign result_count = r_count;

endmodule

// File: tb/tb_cla_result_stage.sv
// Bench for cla_result_stage: queue-based reference model checked every cycle, plus
// directed sequences with literal expectations.
module tb_cla_result_stage;

    logic        Clk;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] S;
    logic        C16;
    logic        A_msb;
    logic        B_msb;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_c;
    logic        out_z;
    logic        out_n;
    logic        out_v;
    logic [7:0]  result_count;

    cla_result_stage #(
        .WIDTH   (16),
        .COUNT_W (8)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .S            (S),
        .C16          (C16),
        .A_msb        (A_msb),
        .B_msb        (B_msb),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_c        (out_c),
        .out_z        (out_z),
        .out_n        (out_n),
        .out_v        (out_v),
        .result_count (result_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } entry_t;

    entry_t     mq[$];
    logic [7:0] mcnt;
    int         total;
    int         bad;
    bit         chk_en;

    initial begin
        total  = 0;
        bad    = 0;
        chk_en = 0;
        mcnt   = 8'd0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of at most two results, flags computed from plain arithmetic.
    always @(posedge Clk) begin
        bit     acc;
        bit     xf;
        entry_t e;
        int     ssum;
        acc = in_valid && !Rst && (mq.size() < 2);
        xf  = (mq.size() > 0) && out_ready;
        if (Rst) begin
            mq.delete();
            mcnt = 8'd0;
        end else begin
            if (xf) begin
                void'(mq.pop_front());
                mcnt = mcnt + 8'd1;
            end
            if (acc) begin
                ssum  = S;
                e.sum = S;
                e.c   = C16;
                e.z   = (ssum == 0);
                e.n   = (ssum >= 32768);
                e.v   = (A_msb == B_msb) && (e.n != A_msb);
                mq.push_back(e);
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, (!Rst && mq.size() < 2)});
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
            chk("m_count", {24'd0, result_count}, {24'd0, mcnt});
            if (mq.size() > 0) begin
                chk("m_sum", {16'd0, out_sum}, {16'd0, mq[0].sum});
                chk("m_flags", {28'd0, out_c, out_z, out_n, out_v},
                    {28'd0, mq[0].c, mq[0].z, mq[0].n, mq[0].v});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        Rst      = 1'b0;
    endtask

    initial begin
        logic [15:0] got[$];
        bit          sent;
        Rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        S         = '0;
        C16       = 1'b0;
        A_msb     = 1'b0;
        B_msb     = 1'b0;

        // Reset held two cycles.
        tick();
        chk_en = 1;
        chk("rst_in_ready_during", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid_during", {31'd0, out_valid}, 32'd0);
        tick();
        Rst = 1'b0;
        #1;
        chk("rst_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("rst_count", {24'd0, result_count}, 32'd0);
        chk("rst_out_sum", {16'd0, out_sum}, 32'd0);

        // Flag cases.
        out_ready = 1'b1;
        in_valid = 1'b1; S = 16'h0000; C16 = 1'b1; A_msb = 1'b1; B_msb = 1'b1;
        tick();
        chk("flag1_valid", {31'd0, out_valid}, 32'd1);
        chk("flag1_czvn", {28'd0, out_c, out_z, out_n, out_v}, 32'b1101);
        in_valid = 1'b1; S = 16'h8000; C16 = 1'b0; A_msb = 1'b0; B_msb = 1'b0;
        tick();
        chk("flag2_sum", {16'd0, out_sum}, 32'h8000);
        chk("flag2_czvn", {28'd0, out_c, out_z, out_n, out_v}, 32'b0011);
        in_valid = 1'b0;
        tick();

        // Back-pressure: two buffered, third held off, then in-order drain.
        out_ready = 1'b0; A_msb = 1'b0; B_msb = 1'b0; C16 = 1'b0;
        in_valid = 1'b1; S = 16'h0001;
        tick();
        S = 16'h0002;
        tick();
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        S = 16'h0003;
        tick();
        tick();
        chk("bp_head_held", {16'd0, out_sum}, 32'h0001);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && got.size() < 3; k++) begin
            sent = in_valid && in_ready;
            if (out_valid) got.push_back(out_sum);
            tick();
            if (sent) in_valid = 1'b0;
        end
        chk("bp_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            chk("bp_order0", {16'd0, got[0]}, 32'h0001);
            chk("bp_order1", {16'd0, got[1]}, 32'h0002);
            chk("bp_order2", {16'd0, got[2]}, 32'h0003);
        end
        in_valid = 1'b0;

        // Streaming: one result per cycle with no bubbles.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            S = 16'(i);
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_sum", {16'd0, out_sum}, i);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_count20", {24'd0, result_count}, 32'd20);

        // Counter wrap after 256 transfers.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            S = 16'($urandom);
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_count255", {24'd0, result_count}, 32'd255);
        tick();
        chk("wrap_count0", {24'd0, result_count}, 32'd0);

        // Randomized traffic with occasional reset, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            Rst       = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       S = 16'h0000;
                1:       S = 16'h8000;
                default: S = 16'($urandom);
            endcase
            C16   = 1'($urandom);
            A_msb = 1'($urandom);
            B_msb = 1'($urandom);
            tick();
        end
        Rst = 1'b0;

        // Reset while full, with simultaneous accept/transfer attempts.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; S = 16'hAAAA;
        tick();
        S = 16'hBBBB;
        tick();
        chk("mid_full", {31'd0, in_ready}, 32'd0);
        Rst = 1'b1; S = 16'hCCCC; out_ready = 1'b1;
        tick();
        Rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_out_sum", {16'd0, out_sum}, 32'd0);
        chk("mid_count", {24'd0, result_count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_ghost", {31'd0, out_valid}, 32'd0);
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
